// File: rtl/gemm_accel_core.sv
// Tiled signed int8 GEMM engine with an output-stationary RowPar x ColPar MAC array,
// plus the single_port_memory companion model. Optional cycle counter: GEMM_PERF_COUNTER_EN.

module single_port_memory #(
  parameter int DataWidth = 32,
  parameter int DataDepth = 4096,
  parameter int AddrWidth = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] mem_addr_i,
  input  logic                 mem_we_i,
  input  logic [DataWidth-1:0] mem_wr_data_i,
  output logic [DataWidth-1:0] mem_rd_data_o
);
  logic [DataWidth-1:0] memory [DataDepth];
  logic [DataWidth-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (mem_we_i) memory[mem_addr_i] <= mem_wr_data_i;
  end

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= memory[mem_addr_i];
  end

  assign mem_rd_data_o = rd_data_q;
endmodule

module gemm_mac_lane #(
  parameter int InDataWidth  = 8,
  parameter int OutDataWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    vld_i,
  input  logic                    clr_i,
  input  logic [InDataWidth-1:0]  a_i,
  input  logic [InDataWidth-1:0]  b_i,
  output logic [OutDataWidth-1:0] acc_o
);
  logic signed [2*InDataWidth-1:0] prod;
  logic [OutDataWidth-1:0]         prod_ext, acc_d, acc_q;

  assign prod     = $signed(a_i) * $signed(b_i);
  assign prod_ext = {{(OutDataWidth-2*InDataWidth){prod[2*InDataWidth-1]}}, prod};
  // First beat of a tile restarts the sum instead of adding to the previous tile.
  assign acc_d    = (clr_i ? '0 : acc_q) + prod_ext;

  always_ff @(posedge clk_i) begin
    if (rst_i)      acc_q <= '0;
    else if (vld_i) acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

module gemm_accel_core #(
  parameter int InDataWidth   = 8,
  parameter int RowPar        = 4,
  parameter int ColPar        = 16,
  parameter int InDataWidth_a = RowPar*InDataWidth,
  parameter int InDataWidth_b = ColPar*InDataWidth,
  parameter int OutDataWidth  = 32,
  parameter int AddrWidth     = 12,
  parameter int SizeAddrWidth = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_i,
  input  logic [SizeAddrWidth-1:0]             M_size_i,
  input  logic [SizeAddrWidth-1:0]             K_size_i,
  input  logic [SizeAddrWidth-1:0]             N_size_i,
  output logic [AddrWidth-1:0]                 sram_a_addr_o,
  output logic [AddrWidth-1:0]                 sram_b_addr_o,
  output logic [AddrWidth-1:0]                 sram_c_addr_o,
  input  logic [InDataWidth_a-1:0]             sram_a_rdata_i,
  input  logic [InDataWidth_b-1:0]             sram_b_rdata_i,
  output logic [RowPar*ColPar*OutDataWidth-1:0] sram_c_wdata_o,
  output logic                                 sram_c_we_o,
`ifdef GEMM_PERF_COUNTER_EN
  output logic                                 done_o,
  output logic [31:0]                          perf_cycles_o
`else
  output logic                                 done_o
`endif
);
  localparam int SW = SizeAddrWidth;
  localparam int AW = AddrWidth;
  localparam int CW = RowPar*ColPar*OutDataWidth;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   k_cnt_q, k_cnt_d, k_size_q, k_size_d;
  logic [SW-1:0]   mt_q, mt_d, nt_q, nt_d, tm_q, tm_d, tn_q, tn_d;
  logic [AW-1:0]   a_base_q, a_base_d, b_base_q, b_base_d, c_idx_q, c_idx_d;
  logic            beat_vld_q, beat_clr_q, issue;
  logic [CW-1:0]   acc_flat, wdata_q;
  logic [SW-1:0]   mt_in, nt_in;
  logic            size_zero, last_tile;

  assign mt_in     = SW'(M_size_i / SW'(RowPar)) + SW'(M_size_i % SW'(RowPar) != '0);
  assign nt_in     = SW'(N_size_i / SW'(ColPar)) + SW'(N_size_i % SW'(ColPar) != '0);
  assign size_zero = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
  assign issue     = (state_q == S_RUN) && (k_cnt_q != k_size_q);
  assign last_tile = (tm_q == mt_q - 1'b1) && (tn_q == nt_q - 1'b1);

  always_comb begin
    state_d     = state_q;
    k_cnt_d     = k_cnt_q;
    k_size_d    = k_size_q;
    mt_d        = mt_q;
    nt_d        = nt_q;
    tm_d        = tm_q;
    tn_d        = tn_q;
    a_base_d    = a_base_q;
    b_base_d    = b_base_q;
    c_idx_d     = c_idx_q;
    sram_c_we_o = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) begin
        k_size_d = K_size_i;
        mt_d     = mt_in;
        nt_d     = nt_in;
        tm_d     = '0;
        tn_d     = '0;
        k_cnt_d  = '0;
        a_base_d = '0;
        b_base_d = '0;
        c_idx_d  = '0;
        state_d  = size_zero ? S_DONE : S_RUN;
      end
      // K issue cycles, then one drain cycle while the last operand returns.
      S_RUN: begin
        if (issue) k_cnt_d = k_cnt_q + 1'b1;
        else       state_d = S_WRITE;
      end
      S_WRITE: begin
        sram_c_we_o = 1'b1;
        c_idx_d     = c_idx_q + 1'b1;
        k_cnt_d     = '0;
        if (last_tile) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
          if (tn_q == nt_q - 1'b1) begin
            tn_d     = '0;
            b_base_d = '0;
            tm_d     = tm_q + 1'b1;
            a_base_d = a_base_q + k_size_q[AW-1:0];
          end else begin
            tn_d     = tn_q + 1'b1;
            b_base_d = b_base_q + k_size_q[AW-1:0];
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      k_cnt_q    <= '0;
      k_size_q   <= '0;
      mt_q       <= '0;
      nt_q       <= '0;
      tm_q       <= '0;
      tn_q       <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      c_idx_q    <= '0;
      beat_vld_q <= 1'b0;
      beat_clr_q <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      k_cnt_q    <= k_cnt_d;
      k_size_q   <= k_size_d;
      mt_q       <= mt_d;
      nt_q       <= nt_d;
      tm_q       <= tm_d;
      tn_q       <= tn_d;
      a_base_q   <= a_base_d;
      b_base_q   <= b_base_d;
      c_idx_q    <= c_idx_d;
      beat_vld_q <= issue;
      beat_clr_q <= issue && (k_cnt_q == '0);
      if (state_q == S_WRITE) wdata_q <= acc_flat;
    end
  end

  assign sram_a_addr_o  = a_base_q + k_cnt_q[AW-1:0];
  assign sram_b_addr_o  = b_base_q + k_cnt_q[AW-1:0];
  assign sram_c_addr_o  = c_idx_q;
  // Accumulators stay live into the next tile, so the held copy covers the time after WRITE.
  assign sram_c_wdata_o = (state_q == S_WRITE) ? acc_flat : wdata_q;

  for (genvar q = 0; q < RowPar; q++) begin : g_row
    for (genvar l = 0; l < ColPar; l++) begin : g_col
      gemm_mac_lane #(
        .InDataWidth (InDataWidth),
        .OutDataWidth(OutDataWidth)
      ) u_lane (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .vld_i(beat_vld_q),
        .clr_i(beat_clr_q),
        .a_i  (sram_a_rdata_i[q*InDataWidth +: InDataWidth]),
        .b_i  (sram_b_rdata_i[l*InDataWidth +: InDataWidth]),
        .acc_o(acc_flat[(q*ColPar+l)*OutDataWidth +: OutDataWidth])
      );
    end
  end

`ifdef GEMM_PERF_COUNTER_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)                               perf_q <= '0;
    else if ((state_q == S_IDLE) && start_i) perf_q <= '0;
    else if (state_q != S_IDLE)              perf_q <= perf_q + 1'b1;
  end
  assign perf_cycles_o = perf_q;
`endif
endmodule

// File: tb/tb_gemm_accel_core.sv
// Directed bench for gemm_accel_core: operands loaded through the SRAM write ports,
// C writes captured from the write port and compared to a plain matrix-product model.
module tb_gemm_accel_core;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   m_sz = '0, k_sz = '0, n_sz = '0;
  logic [11:0]   a_addr, b_addr, c_addr;
  logic [31:0]   a_rdata;
  logic [127:0]  b_rdata;
  logic [2047:0] c_wdata;
  logic          c_we, done;
`ifdef GEMM_PERF_COUNTER_EN
  logic [31:0]   perf_cycles;
`endif

  logic          ld_en = 1'b0, ld_we_a = 1'b0, ld_we_b = 1'b0;
  logic [11:0]   ld_addr_a = '0, ld_addr_b = '0;
  logic [31:0]   ld_data_a = '0;
  logic [127:0]  ld_data_b = '0;
  logic [11:0]   mem_a_addr, mem_b_addr;

  logic signed [7:0] am [32][32];
  logic signed [7:0] bm [32][32];

  int n_tests = 0, n_fail = 0, done_cnt = 0;
  logic [11:0]   wr_addr_q [$];
  logic [2047:0] wr_data_q [$];

  always #5 clk = ~clk;

  assign mem_a_addr = ld_en ? ld_addr_a : a_addr;
  assign mem_b_addr = ld_en ? ld_addr_b : b_addr;

  single_port_memory #(.DataWidth(32), .DataDepth(4096), .AddrWidth(12)) u_mem_a (
    .clk_i(clk), .rst_i(rst), .mem_addr_i(mem_a_addr), .mem_we_i(ld_we_a),
    .mem_wr_data_i(ld_data_a), .mem_rd_data_o(a_rdata));
  single_port_memory #(.DataWidth(128), .DataDepth(4096), .AddrWidth(12)) u_mem_b (
    .clk_i(clk), .rst_i(rst), .mem_addr_i(mem_b_addr), .mem_we_i(ld_we_b),
    .mem_wr_data_i(ld_data_b), .mem_rd_data_o(b_rdata));

  gemm_accel_core dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .M_size_i(m_sz), .K_size_i(k_sz), .N_size_i(n_sz),
    .sram_a_addr_o(a_addr), .sram_b_addr_o(b_addr), .sram_c_addr_o(c_addr),
    .sram_a_rdata_i(a_rdata), .sram_b_rdata_i(b_rdata),
    .sram_c_wdata_o(c_wdata), .sram_c_we_o(c_we),
`ifdef GEMM_PERF_COUNTER_EN
    .done_o(done), .perf_cycles_o(perf_cycles)
`else
    .done_o(done)
`endif
  );

  always @(negedge clk) begin
    if (c_we) begin
      wr_addr_q.push_back(c_addr);
      wr_data_q.push_back(c_wdata);
    end
    if (done) done_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int gold(int r, int c, int k);
    int s = 0;
    for (int i = 0; i < k; i++) s += int'(am[r][i]) * int'(bm[i][c]);
    return s;
  endfunction

  task automatic load_mats(int m, int k, int n);
    int mt = (m + 3) / 4;
    int nt = (n + 15) / 16;
    int na = mt * k, nb = nt * k;
    int nmax = (na > nb) ? na : nb;
    logic [31:0]  wa;
    logic [127:0] wb;
    @(negedge clk);
    ld_en = 1'b1;
    for (int i = 0; i < nmax; i++) begin
      wa = '0;
      wb = '0;
      for (int q = 0; q < 4; q++)
        if ((i / k) * 4 + q < m) wa[q*8 +: 8] = am[(i / k) * 4 + q][i % k];
      for (int l = 0; l < 16; l++)
        if ((i / k) * 16 + l < n) wb[l*8 +: 8] = bm[i % k][(i / k) * 16 + l];
      ld_we_a = (i < na); ld_addr_a = 12'(i); ld_data_a = wa;
      ld_we_b = (i < nb); ld_addr_b = 12'(i); ld_data_b = wb;
      @(negedge clk);
    end
    ld_we_a = 1'b0; ld_we_b = 1'b0; ld_en = 1'b0;
  endtask

  // lat = cycle (start cycle = 0) in which done_o is seen; pulse_at injects a stray start.
  task automatic run_gemm(int m, int k, int n, int pulse_at, output int lat);
    wr_addr_q.delete(); wr_data_q.delete(); done_cnt = 0;
    @(negedge clk);
    m_sz = m; k_sz = k; n_sz = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0; m_sz = 7; k_sz = 9; n_sz = 3;
    lat = 1;
    while (!done && lat < 20000) begin
      start = (lat == pulse_at);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic check_tiles(string nm, int m, int k, int n);
    int nt = (n + 15) / 16;
    int errs, tm, tn, r, c, exp_v, got;
    logic [2047:0] w;
    for (int i = 0; i < wr_data_q.size(); i++) begin
      n_tests++;
      if (wr_addr_q[i] !== 12'(i)) begin
        n_fail++; $display("FAIL %s addr[%0d]: got %0d expected %0d", nm, i, wr_addr_q[i], i);
      end
      w = wr_data_q[i]; errs = 0; tm = i / nt; tn = i % nt;
      for (int q = 0; q < 4; q++)
        for (int l = 0; l < 16; l++) begin
          r = tm * 4 + q; c = tn * 16 + l;
          exp_v = (r < m && c < n) ? gold(r, c, k) : 0;
          got = int'(w[(q*16+l)*32 +: 32]);
          if (got !== exp_v) begin
            if (errs == 0) $display("FAIL %s tile %0d elem(%0d,%0d): got %0d expected %0d", nm, i, q, l, got, exp_v);
            errs++;
          end
        end
      n_tests++;
      if (errs != 0) n_fail++;
    end
  endtask

  task automatic check_run(string nm, int lat, int exp_lat, int exp_wr);
    n_tests++;
    if (lat !== exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", nm, lat, exp_lat); end
    n_tests++;
    if (wr_data_q.size() !== exp_wr) begin n_fail++; $display("FAIL %s writes: got %0d expected %0d", nm, wr_data_q.size(), exp_wr); end
    n_tests++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL %s done pulses: got %0d expected 1", nm, done_cnt); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++;
    if ({a_addr, b_addr, c_addr} !== 36'd0) begin
      n_fail++; $display("FAIL reset addrs: got %h expected 0", {a_addr, b_addr, c_addr});
    end
    n_tests++;
    if (c_wdata !== '0) begin n_fail++; $display("FAIL reset wdata: got nonzero expected 0"); end
    n_tests++;
    if ({c_we, done} !== 2'b00) begin n_fail++; $display("FAIL reset we/done: got %b expected 00", {c_we, done}); end
`ifdef GEMM_PERF_COUNTER_EN
    n_tests++;
    if (perf_cycles !== 32'd0) begin n_fail++; $display("FAIL reset perf: got %0d expected 0", perf_cycles); end
`endif
    rst = 1'b0;
    wr_addr_q.delete(); wr_data_q.delete(); done_cnt = 0;
    repeat (10) @(negedge clk);
    n_tests++;
    if (done_cnt !== 0 || wr_data_q.size() !== 0) begin
      n_fail++; $display("FAIL idle activity: got done=%0d writes=%0d expected 0/0", done_cnt, wr_data_q.size());
    end
  endtask

  task automatic test_zero_size();
    int lat;
    run_gemm(4, 0, 16, -1, lat);
    check_run("k_zero", lat, 1, 0);
    run_gemm(0, 4, 4, -1, lat);
    check_run("m_zero", lat, 1, 0);
  endtask

  task automatic test_full_32();
    int lat;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++) begin
        am[i][j] = 8'($urandom);
        bm[i][j] = 8'($urandom);
      end
    load_mats(32, 32, 32);
    run_gemm(32, 32, 32, -1, lat);
    check_run("full32", lat, 16 * 34 + 1, 16);
    check_tiles("full32", 32, 32, 32);
  endtask

  // A = 1 everywhere, B(k,l) = l-8: C(r,l) = 64*(l-8). A stray start mid-run must be ignored.
  task automatic test_latency_midstart();
    int lat, errs, got;
    logic [2047:0] w;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++) begin
        am[i][j] = 8'sd1;
        bm[i][j] = 8'(j - 8);
      end
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) am[j][32 + 0 - 32 + i] = 8'sd1;
    end
    load_mats(4, 64 > 32 ? 32 : 32, 16);
    // K=64 needs 64 columns; reload explicitly with a constant operand pair
    @(negedge clk);
    ld_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ld_we_a = 1'b1; ld_addr_a = 12'(i); ld_data_a = 32'h0101_0101;
      ld_we_b = 1'b1; ld_addr_b = 12'(i);
      for (int l = 0; l < 16; l++) ld_data_b[l*8 +: 8] = 8'(l - 8);
      @(negedge clk);
    end
    ld_we_a = 1'b0; ld_we_b = 1'b0; ld_en = 1'b0;
    run_gemm(4, 64, 16, 20, lat);
    check_run("lat64", lat, 67, 1);
    if (wr_data_q.size() > 0) begin
      w = wr_data_q[0]; errs = 0;
      for (int q = 0; q < 4; q++)
        for (int l = 0; l < 16; l++) begin
          got = int'(w[(q*16+l)*32 +: 32]);
          if (got !== 64 * (l - 8)) begin
            if (errs == 0) $display("FAIL lat64 elem(%0d,%0d): got %0d expected %0d", q, l, got, 64 * (l - 8));
            errs++;
          end
        end
      n_tests++;
      if (errs != 0) n_fail++;
    end
    n_tests++;
    if (c_wdata[15*32 +: 32] !== 32'd448) begin
      n_fail++; $display("FAIL wdata hold: got %0d expected 448", c_wdata[15*32 +: 32]);
    end
`ifdef GEMM_PERF_COUNTER_EN
    n_tests++;
    if (perf_cycles !== 32'd67) begin n_fail++; $display("FAIL perf count: got %0d expected 67", perf_cycles); end
`endif
  endtask

  task automatic test_min_neg();
    int lat, errs, got;
    logic [2047:0] w;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++) begin
        am[i][j] = 8'sh80;
        bm[i][j] = 8'sh80;
      end
    load_mats(4, 4, 16);
    run_gemm(4, 4, 16, -1, lat);
    check_run("minneg", lat, 7, 1);
    if (wr_data_q.size() > 0) begin
      w = wr_data_q[0]; errs = 0;
      for (int e = 0; e < 64; e++) begin
        got = int'(w[e*32 +: 32]);
        if (got !== 65536) begin
          if (errs == 0) $display("FAIL minneg elem %0d: got %0d expected 65536", e, got);
          errs++;
        end
      end
      n_tests++;
      if (errs != 0) n_fail++;
    end
  endtask

  task automatic test_padded();
    int lat;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++) begin
        am[i][j] = 8'($urandom);
        bm[i][j] = 8'($urandom);
      end
    load_mats(5, 3, 17);
    run_gemm(5, 3, 17, -1, lat);
    check_run("padded", lat, 4 * 5 + 1, 4);
    check_tiles("padded", 5, 3, 17);
  endtask

  task automatic test_abort();
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++) begin
        am[i][j] = 8'($urandom);
        bm[i][j] = 8'($urandom);
      end
    load_mats(32, 32, 32);
    @(negedge clk);
    m_sz = 32; k_sz = 32; n_sz = 32; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({c_we, done, a_addr, b_addr, c_addr} !== 38'd0 || c_wdata !== '0) begin
      n_fail++; $display("FAIL abort reset state: got we=%b done=%b a=%0d b=%0d c=%0d", c_we, done, a_addr, b_addr, c_addr);
    end
    rst = 1'b0;
    wr_addr_q.delete(); wr_data_q.delete(); done_cnt = 0;
    repeat (700) @(negedge clk);
    n_tests++;
    if (done_cnt !== 0 || wr_data_q.size() !== 0) begin
      n_fail++; $display("FAIL abort activity: got done=%0d writes=%0d expected 0/0", done_cnt, wr_data_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero_size();
    test_full_32();
    test_latency_midstart();
    test_min_neg();
    test_padded();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
